// File: rtl/dstack.sv
// Register-file data stack with a hardwired top/second/third view, indexed
// rotate/copy access and sticky overflow/underflow error flags.
module dstack #(
    parameter int WORD_WIDTH = 32,
    parameter int DEPTH      = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic [1:0]            movement,
    input  logic [WORD_WIDTH-1:0] next_top,
    input  logic                  rotate,
    input  logic [5:0]            rotate_addr,
    input  logic                  clear_flags,
    output logic [WORD_WIDTH-1:0] top,
    output logic [WORD_WIDTH-1:0] second,
    output logic [WORD_WIDTH-1:0] third,
    output logic [WORD_WIDTH-1:0] rotate_value,
    output logic [6:0]            depth,
    output logic                  empty,
    output logic                  full,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [1:0] MV_HOLD = 2'b00;
    localparam logic [1:0] MV_PUSH = 2'b01;
    localparam logic [1:0] MV_POP1 = 2'b10;
    localparam logic [1:0] MV_POP2 = 2'b11;

    localparam logic [6:0] DEPTH_MAX = 7'(DEPTH);

    logic [WORD_WIDTH-1:0] e_q [DEPTH];
    logic [WORD_WIDTH-1:0] e_d [DEPTH];
    logic [6:0]            depth_q;
    logic [6:0]            depth_d;
    logic                  overflow_q;
    logic                  overflow_d;
    logic                  underflow_q;
    logic                  underflow_d;
    logic                  ovf_event;
    logic                  unf_event;

    // Entry shifting. Entry 0 always takes next_top: the control supplies the
    // push value, the ALU result of a pop, or the rotated-out entry.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            e_d[i] = e_q[i];
        end
        case (movement)
            MV_HOLD: begin
                if (rotate) begin
                    for (int i = 1; i < DEPTH; i++) begin
                        if (i <= int'(rotate_addr)) begin
                            e_d[i] = e_q[i-1];
                        end
                    end
                end
            end
            MV_PUSH: begin
                for (int i = 1; i < DEPTH; i++) begin
                    e_d[i] = e_q[i-1];
                end
            end
            MV_POP1: begin
                for (int i = 1; i < DEPTH - 1; i++) begin
                    e_d[i] = e_q[i+1];
                end
                e_d[DEPTH-1] = '0;
            end
            default: begin
                for (int i = 1; i < DEPTH - 2; i++) begin
                    e_d[i] = e_q[i+2];
                end
                e_d[DEPTH-2] = '0;
                e_d[DEPTH-1] = '0;
            end
        endcase
        e_d[0] = next_top;
    end

    // A pop of n also writes its result back into the top slot, so it needs
    // more than n valid entries; a pop that reaches zero is flagged.
    always_comb begin
        depth_d   = depth_q;
        ovf_event = 1'b0;
        unf_event = 1'b0;
        case (movement)
            MV_PUSH: begin
                if (depth_q == DEPTH_MAX) begin
                    ovf_event = 1'b1;
                end else begin
                    depth_d = depth_q + 7'd1;
                end
            end
            MV_POP1: begin
                if (depth_q <= 7'd1) begin
                    unf_event = 1'b1;
                    depth_d   = '0;
                end else begin
                    depth_d = depth_q - 7'd1;
                end
            end
            MV_POP2: begin
                if (depth_q <= 7'd2) begin
                    unf_event = 1'b1;
                    depth_d   = '0;
                end else begin
                    depth_d = depth_q - 7'd2;
                end
            end
            default: begin
                depth_d = depth_q;
            end
        endcase
        overflow_d  = (overflow_q  & ~clear_flags) | ovf_event;
        underflow_d = (underflow_q & ~clear_flags) | unf_event;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                e_q[i] <= '0;
            end
            depth_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (!stall) begin
            for (int i = 0; i < DEPTH; i++) begin
                e_q[i] <= e_d[i];
            end
            depth_q     <= depth_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign top          = e_q[0];
    assign second       = e_q[1];
    assign third        = e_q[2];
    assign rotate_value = e_q[rotate_addr];
    assign depth        = depth_q;
    assign empty        = (depth_q == 7'd0);
    assign full         = (depth_q == DEPTH_MAX);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_dstack.sv
// Directed bench for dstack: push/pop/rotate/copy, saturation flags, stall
// and asynchronous reset, checked with immediate assertions.
module tb_dstack;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [1:0]  movement;
    logic [31:0] next_top;
    logic        rotate;
    logic [5:0]  rotate_addr;
    logic        clear_flags;
    logic [31:0] top;
    logic [31:0] second;
    logic [31:0] third;
    logic [31:0] rotate_value;
    logic [6:0]  depth;
    logic        empty;
    logic        full;
    logic        overflow;
    logic        underflow;

    int checks;
    int failures;

    dstack #(.WORD_WIDTH(32), .DEPTH(64)) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .movement     (movement),
        .next_top     (next_top),
        .rotate       (rotate),
        .rotate_addr  (rotate_addr),
        .clear_flags  (clear_flags),
        .top          (top),
        .second       (second),
        .third        (third),
        .rotate_value (rotate_value),
        .depth        (depth),
        .empty        (empty),
        .full         (full),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one operation, let one rising edge take it, then settle past the edge.
    task automatic step(input logic [1:0] mv, input logic [31:0] nt, input logic rot,
                        input logic [5:0] addr, input logic clr);
        movement    = mv;
        next_top    = nt;
        rotate      = rot;
        rotate_addr = addr;
        clear_flags = clr;
        @(posedge clk);
        #1;
        rotate      = 1'b0;
        clear_flags = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #2;
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        reset       = 1'b1;
        stall       = 1'b0;
        movement    = 2'b00;
        next_top    = '0;
        rotate      = 1'b0;
        rotate_addr = '0;
        clear_flags = 1'b0;

        // Reset state
        #3;
        chk("rst_top", top, 32'd0);
        chk("rst_depth", 32'(depth), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_unf", 32'(underflow), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;

        // Push 1,2,3
        step(2'b01, 32'd1, 1'b0, 6'd0, 1'b0);
        step(2'b01, 32'd2, 1'b0, 6'd0, 1'b0);
        step(2'b01, 32'd3, 1'b0, 6'd0, 1'b0);
        chk("push_top", top, 32'd3);
        chk("push_second", second, 32'd2);
        chk("push_third", third, 32'd1);
        chk("push_depth", 32'(depth), 32'd3);
        chk("push_empty", 32'(empty), 32'd0);

        // Pop one (binary op result 5), then pop two reaching zero
        step(2'b10, 32'd5, 1'b0, 6'd0, 1'b0);
        chk("pop1_top", top, 32'd5);
        chk("pop1_second", second, 32'd1);
        chk("pop1_depth", 32'(depth), 32'd2);
        chk("pop1_unf", 32'(underflow), 32'd0);
        step(2'b11, 32'd9, 1'b0, 6'd0, 1'b0);
        chk("pop2_top", top, 32'd9);
        chk("pop2_second", second, 32'd0);
        chk("pop2_depth", 32'(depth), 32'd0);
        chk("pop2_unf", 32'(underflow), 32'd1);
        chk("pop2_empty", 32'(empty), 32'd1);

        // Hold with clear_flags clears underflow; hold keeps depth
        step(2'b00, 32'd9, 1'b0, 6'd0, 1'b1);
        chk("clr_unf", 32'(underflow), 32'd0);
        chk("hold_top", top, 32'd9);
        chk("hold_depth", 32'(depth), 32'd0);

        // Pop on an empty stack with clear_flags in the same cycle: event wins
        step(2'b10, 32'd0, 1'b0, 6'd0, 1'b1);
        chk("unf_wins_clear", 32'(underflow), 32'd1);
        chk("unf_depth", 32'(depth), 32'd0);

        // Rotate: build 4,3,2,1
        do_reset();
        chk("rst2_unf", 32'(underflow), 32'd0);
        step(2'b01, 32'd1, 1'b0, 6'd0, 1'b0);
        step(2'b01, 32'd2, 1'b0, 6'd0, 1'b0);
        step(2'b01, 32'd3, 1'b0, 6'd0, 1'b0);
        step(2'b01, 32'd4, 1'b0, 6'd0, 1'b0);
        rotate_addr = 6'd2;
        #1;
        chk("rotval_k2", rotate_value, 32'd2);
        step(2'b00, 32'd2, 1'b1, 6'd2, 1'b0);
        chk("rot_top", top, 32'd2);
        chk("rot_second", second, 32'd4);
        chk("rot_third", third, 32'd3);
        chk("rot_depth", 32'(depth), 32'd4);
        rotate_addr = 6'd3;
        #1;
        chk("rot_e3", rotate_value, 32'd1);

        // Rotate with k==0 behaves as hold
        step(2'b00, 32'd2, 1'b1, 6'd0, 1'b0);
        chk("rot0_top", top, 32'd2);
        chk("rot0_second", second, 32'd4);
        chk("rot0_third", third, 32'd3);

        // Copy: push of rotate_value with rotate ignored (stack 2,4,3,1 -> 3,2,4,3,1)
        step(2'b01, 32'd3, 1'b1, 6'd2, 1'b0);
        chk("copy_top", top, 32'd3);
        chk("copy_second", second, 32'd2);
        chk("copy_third", third, 32'd4);
        chk("copy_depth", 32'(depth), 32'd5);
        rotate_addr = 6'd4;
        #1;
        chk("copy_e4", rotate_value, 32'd1);

        // Read beyond depth returns stored contents (never written -> 0)
        rotate_addr = 6'd10;
        #1;
        chk("read_beyond", rotate_value, 32'd0);
        chk("read_beyond_unf", 32'(underflow), 32'd0);

        // Fill: push 1..65
        do_reset();
        for (int v = 1; v <= 65; v++) begin
            step(2'b01, 32'(v), 1'b0, 6'd0, 1'b0);
        end
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_ovf", 32'(overflow), 32'd1);
        chk("fill_depth", 32'(depth), 32'd64);
        chk("fill_top", top, 32'd65);
        rotate_addr = 6'd63;
        #1;
        chk("fill_e63", rotate_value, 32'd2);
        step(2'b00, 32'd65, 1'b0, 6'd63, 1'b1);
        chk("clr_ovf", 32'(overflow), 32'd0);
        chk("clr_full", 32'(full), 32'd1);

        // Overflow event beats clear_flags; the shift still happens
        step(2'b01, 32'd66, 1'b0, 6'd63, 1'b1);
        chk("ovf_wins_clear", 32'(overflow), 32'd1);
        chk("ovf_depth", 32'(depth), 32'd64);
        chk("ovf_top", top, 32'd66);
        chk("ovf_e63", rotate_value, 32'd3);

        // Stall: push of 7 with clear_flags has no effect; rotate_value stays live
        stall = 1'b1;
        step(2'b01, 32'd7, 1'b0, 6'd63, 1'b1);
        chk("stall_top", top, 32'd66);
        chk("stall_second", second, 32'd65);
        chk("stall_depth", 32'(depth), 32'd64);
        chk("stall_ovf", 32'(overflow), 32'd1);
        rotate_addr = 6'd1;
        #1;
        chk("stall_rotval", rotate_value, 32'd65);
        stall = 1'b0;

        // Asynchronous reset in the middle of a push sequence
        do_reset();
        step(2'b01, 32'd11, 1'b0, 6'd0, 1'b0);
        step(2'b01, 32'd12, 1'b0, 6'd0, 1'b0);
        movement = 2'b01;
        next_top = 32'd13;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("async_top", top, 32'd0);
        chk("async_second", second, 32'd0);
        chk("async_depth", 32'(depth), 32'd0);
        chk("async_empty", 32'(empty), 32'd1);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_top", top, 32'd13);
        chk("post_rst_second", second, 32'd0);
        chk("post_rst_depth", 32'(depth), 32'd1);
        movement = 2'b00;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
